// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit path
package uart_pkg;

    // Widest supported frame payload; narrower words are zero-extended in the FIFO entry.
    localparam int MAX_DATA_W = 9;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    typedef struct packed {
        logic                  stop2;
        parity_mode_e          mode;
        logic [MAX_DATA_W-1:0] data;
    } tx_entry_t;

    function automatic logic has_parity(input parity_mode_e m);
        return (m == PAR_EVEN) || (m == PAR_ODD);
    endfunction

    // Zero-extended upper bits do not disturb the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] d, input parity_mode_e m);
        return (^d) ^ (m == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer-side word handshake into the UART transmitter
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8
);
    logic              VALID;
    logic              READY;
    logic [DATA_W-1:0] DATA_IN;
    logic [1:0]        PARITY_MODE;
    logic              STOP2;

    modport master (
        output VALID,
        output DATA_IN,
        output PARITY_MODE,
        output STOP2,
        input  READY
    );

    modport slave (
        input  VALID,
        input  DATA_IN,
        input  PARITY_MODE,
        input  STOP2,
        output READY
    );
endinterface

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO of transmit entries with full/empty/level
module uart_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          push,
    input  tx_entry_t     wr_data,
    input  logic          pop,
    output tx_entry_t     rd_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    tx_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage needs no reset: occupancy is governed solely by count.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with per-word parity and stop-bit options
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 4,
    parameter  int DIV_W      = 16,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    uart_tx_fifo_if.slave    tx_if,
    input  logic [DIV_W-1:0] BAUD_DIV,
    output logic             TXD,
    output logic             BUSY,
    output logic [LVL_W-1:0] FIFO_LEVEL
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    tx_entry_t             wr_entry;
    tx_entry_t             head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  load;

    tx_state_e             state_q, state_d;
    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [3:0]            bit_q, bit_d;
    logic [MAX_DATA_W-1:0] sh_q, sh_d;
    logic                  par_q, par_d;
    parity_mode_e          mode_q, mode_d;
    logic                  stop2_q, stop2_d;
    logic                  txd_q, txd_d;
    logic                  bit_end;

    always_comb begin
        wr_entry       = '0;
        wr_entry.data  = MAX_DATA_W'(tx_if.DATA_IN);
        wr_entry.mode  = parity_mode_e'(tx_if.PARITY_MODE);
        wr_entry.stop2 = tx_if.STOP2;
    end

    uart_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push    (tx_if.VALID),
        .wr_data (wr_entry),
        .pop     (load),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (FIFO_LEVEL)
    );

    assign tx_if.READY = !fifo_full;
    assign TXD         = txd_q;
    assign BUSY        = (state_q != IDLE);
    assign bit_end     = (cnt_q == div_q);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            mode_q  <= PAR_NONE;
            stop2_q <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            mode_q  <= mode_d;
            stop2_q <= stop2_d;
            txd_q   <= txd_d;
        end
    end

    // txd_d always carries the level of the bit being entered, so TXD switches with the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        mode_d  = mode_q;
        stop2_d = stop2_q;
        txd_d   = txd_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                load  = !fifo_empty;
            end

            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = sh_q[0];
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == LAST_BIT) begin
                        if (has_parity(mode_q)) begin
                            state_d = PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = STOP;
                            bit_d   = '0;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        sh_d  = sh_q >> 1;
                        txd_d = sh_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            STOP: begin
                if (bit_end) begin
                    if (stop2_q && (bit_q == '0)) begin
                        cnt_d = '0;
                        bit_d = 4'd1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        txd_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // The divisor is latched per frame so mid-frame BAUD_DIV changes cannot stretch bits.
        if (load) begin
            state_d = START;
            cnt_d   = '0;
            bit_d   = '0;
            div_d   = BAUD_DIV;
            sh_d    = head.data;
            mode_d  = head.mode;
            stop2_d = head.stop2;
            par_d   = parity_bit(head.data, head.mode);
            txd_d   = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          div;
    } frame_t;

    logic        CLK;
    logic        RST_N;
    logic [15:0] BAUD_DIV;
    logic        TXD;
    logic        BUSY;
    logic [2:0]  FIFO_LEVEL;

    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          extra     = 0;
    int          stalls    = 0;
    int          nfr       = 0;
    bit          in_frame  = 0;

    frame_t      exp_q[$];
    logic [15:0] obs_log[$];
    int          start_log[$];
    int          end_log[$];

    uart_tx_fifo_if #(.DATA_W(8)) tx_if ();

    uart_tx_fifo #(
        .DATA_W     (8),
        .FIFO_DEPTH (4),
        .DIV_W      (16)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .tx_if      (tx_if),
        .BAUD_DIV   (BAUD_DIV),
        .TXD        (TXD),
        .BUSY       (BUSY),
        .FIFO_LEVEL (FIFO_LEVEL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic frame_t make_frame(input logic [7:0] d, input logic [1:0] m,
                                          input logic s2, input int div);
        frame_t f;
        int     n;
        f.bits = '0;
        n = 0;
        f.bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin
            f.bits[n] = d[i]; n++;
        end
        if (m == 2'b01 || m == 2'b10) begin
            f.bits[n] = (^d) ^ (m == 2'b10); n++;
        end
        f.bits[n] = 1'b1; n++;
        if (s2) begin
            f.bits[n] = 1'b1; n++;
        end
        f.nbits = n;
        f.div   = div;
        return f;
    endfunction

    function automatic int get_start(input int i);
        return (i < start_log.size()) ? start_log[i] : -1;
    endfunction

    function automatic int get_end(input int i);
        return (i < end_log.size()) ? end_log[i] : -1;
    endfunction

    function automatic logic [15:0] get_obs(input int i);
        return (i < obs_log.size()) ? obs_log[i] : 16'hffff;
    endfunction

    // Decodes TXD at negedges and checks each bit holds its level for exactly div+1 cycles.
    initial begin : monitor
        frame_t      f;
        int          good;
        int          st;
        bit          ab;
        logic [15:0] ob;
        forever begin
            @(negedge CLK);
            if (RST_N === 1'b1 && TXD === 1'b0) begin
                if (exp_q.size() == 0) begin
                    extra++;
                    while (TXD === 1'b0 && RST_N === 1'b1) @(negedge CLK);
                end else begin
                    f        = exp_q.pop_front();
                    ab       = 0;
                    st       = cyc;
                    ob       = '0;
                    in_frame = 1;
                    for (int b = 0; b < f.nbits && !ab; b++) begin
                        good = 0;
                        for (int c = 0; c <= f.div && !ab; c++) begin
                            if (b != 0 || c != 0) @(negedge CLK);
                            if (RST_N !== 1'b1) begin
                                ab = 1;
                            end else begin
                                if (c == 0) ob[b] = TXD;
                                if (TXD === f.bits[b]) good++;
                            end
                        end
                        if (!ab) check_eq($sformatf("frame%0d_bit%0d", nfr, b), good, f.div + 1);
                    end
                    if (!ab) begin
                        obs_log.push_back(ob);
                        start_log.push_back(st);
                        end_log.push_back(cyc);
                    end
                    nfr++;
                    in_frame = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] m, input logic s2, output int acc);
        int w;
        @(negedge CLK);
        tx_if.VALID       = 1'b1;
        tx_if.DATA_IN     = d;
        tx_if.PARITY_MODE = m;
        tx_if.STOP2       = s2;
        w = 0;
        if (tx_if.READY !== 1'b1) begin
            stalls++;
            check_eq("level_when_not_ready", FIFO_LEVEL, 4);
        end
        while (tx_if.READY !== 1'b1 && w < 3000) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 3000) check_eq("ready_timeout", w, 0);
        @(posedge CLK);
        acc = cyc + 1;
        exp_q.push_back(make_frame(d, m, s2, int'(BAUD_DIV)));
    endtask

    task automatic drop_valid();
        @(negedge CLK);
        tx_if.VALID = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int w;
        w = 0;
        while (w < 5000 && !(exp_q.size() == 0 && !in_frame && BUSY === 1'b0)) begin
            @(negedge CLK);
            w++;
        end
        repeat (3) @(negedge CLK);
        check_eq({tag, "_drained"}, (exp_q.size() == 0 && !in_frame && BUSY === 1'b0), 1);
    endtask

    initial begin : stim
        int          acc;
        int          acc0;
        int          base;
        int          idle;
        logic [15:0] ob;
        logic [7:0]  words [6];

        RST_N             = 1'b0;
        BAUD_DIV          = '0;
        tx_if.VALID       = 1'b0;
        tx_if.DATA_IN     = '0;
        tx_if.PARITY_MODE = 2'b00;
        tx_if.STOP2       = 1'b0;

        repeat (3) @(negedge CLK);
        check_eq("rst_txd", TXD, 1);
        check_eq("rst_busy", BUSY, 0);
        check_eq("rst_level", FIFO_LEVEL, 0);
        check_eq("rst_ready", tx_if.READY, 1);
        #2 RST_N = 1'b1;

        // A3, no parity, one stop, fastest baud
        base = obs_log.size();
        send(8'hA3, 2'b00, 1'b0, acc);
        drop_valid();
        wait_done("a3");
        check_eq("a3_frames", obs_log.size() - base, 1);
        check_eq("a3_latency", get_start(base), acc + 1);
        ob = get_obs(base);
        check_eq("a3_bits", ob[9:0], 10'h346);
        check_eq("a3_busy_low", BUSY, 0);
        check_eq("a3_txd_idle", TXD, 1);

        // Even then odd parity, back to back
        BAUD_DIV = 16'd1;
        base = obs_log.size();
        send(8'hF4, 2'b01, 1'b0, acc);
        send(8'h4F, 2'b10, 1'b0, acc);
        drop_valid();
        wait_done("par");
        check_eq("par_frames", obs_log.size() - base, 2);
        ob = get_obs(base);
        check_eq("par_even_f4", ob[9], 1);
        ob = get_obs(base + 1);
        check_eq("par_odd_4f", ob[9], 0);
        check_eq("par_back_to_back", get_start(base + 1), get_end(base) + 1);

        // Two stop bits, 4-cycle bits
        BAUD_DIV = 16'd3;
        base = obs_log.size();
        send(8'h55, 2'b00, 1'b1, acc);
        drop_valid();
        wait_done("stop2");
        check_eq("stop2_frames", obs_log.size() - base, 1);
        check_eq("stop2_len", get_end(base) - get_start(base) + 1, 44);

        // Six words with VALID held high: FIFO fills and back-pressures once
        BAUD_DIV = 16'd7;
        base   = obs_log.size();
        stalls = 0;
        words  = '{8'h11, 8'h9C, 8'h00, 8'hFF, 8'h5A, 8'hC3};
        for (int i = 0; i < 6; i++) begin
            send(words[i], 2'(i % 3), 1'(i % 2), acc);
        end
        drop_valid();
        check_eq("burst_stalls", stalls, 1);
        wait_done("burst");
        check_eq("burst_frames", obs_log.size() - base, 6);

        // Reset during DATA of the first of three queued words
        BAUD_DIV = 16'd3;
        send(8'hE7, 2'b00, 1'b0, acc0);
        send(8'h18, 2'b00, 1'b0, acc);
        send(8'h3C, 2'b00, 1'b0, acc);
        drop_valid();
        while (cyc < acc0 + 10) @(negedge CLK);
        check_eq("mid_busy", BUSY, 1);
        check_eq("mid_level", FIFO_LEVEL, 2);
        #2 RST_N = 1'b0;
        #1;
        check_eq("abort_txd", TXD, 1);
        check_eq("abort_level", FIFO_LEVEL, 0);
        check_eq("abort_busy", BUSY, 0);
        check_eq("abort_ready", tx_if.READY, 1);
        exp_q.delete();
        repeat (3) @(negedge CLK);
        #2 RST_N = 1'b1;
        idle = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (TXD === 1'b1 && BUSY === 1'b0) idle++;
        end
        check_eq("post_abort_idle", idle, 40);

        // First edge after reset release accepts a word
        BAUD_DIV = 16'd2;
        @(negedge CLK);
        #2 RST_N = 1'b0;
        @(negedge CLK);
        #2;
        RST_N             = 1'b1;
        tx_if.VALID       = 1'b1;
        tx_if.DATA_IN     = 8'h96;
        tx_if.PARITY_MODE = 2'b01;
        tx_if.STOP2       = 1'b0;
        #1 check_eq("release_ready", tx_if.READY, 1);
        base = obs_log.size();
        @(posedge CLK);
        acc = cyc + 1;
        exp_q.push_back(make_frame(8'h96, 2'b01, 1'b0, 2));
        @(negedge CLK);
        tx_if.VALID = 1'b0;
        check_eq("release_level", FIFO_LEVEL, 1);
        wait_done("release");
        check_eq("release_latency", get_start(base), acc + 1);

        check_eq("extra_frames", extra, 0);
        check_eq("leftover_expected", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
